// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 4-digit 7-segment scanner: display geometry,
// "all dark" drive constants and the digit byte-select helper.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 8;

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = 4'hF;
  localparam logic [6:0]            SEG_OFF = 7'h7F;

  typedef logic [1:0] digit_t;

  // One registered snapshot of everything driven onto the display pins.
  typedef struct packed {
    logic [NUM_DIGITS-1:0] an_n;
    logic [6:0]            seg_n;
    logic                  dp_n;
  } drive_t;

  localparam drive_t DRIVE_OFF = '{an_n: AN_OFF, seg_n: SEG_OFF, dp_n: 1'b1};

  // Byte for digit idx of a packed image; digit 0 is the rightmost byte.
  function automatic logic [SEG_W-1:0] digit_byte(
    input logic [NUM_DIGITS*SEG_W-1:0] image,
    input digit_t                      idx
  );
    digit_byte = image[32'(idx) * SEG_W +: SEG_W];
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Bundle between the image producer / display pins and the scanner.
// master = the side supplying the image and controls, slave = the scanner.
interface seven_seg_scanner_if;

  logic [31:0] board7SD;
  logic        enable;
  logic [2:0]  brightness;
  logic [3:0]  blinkEn;
  logic [3:0]  anN;
  logic [6:0]  segN;
  logic        dpN;
  logic        frameStart;

  modport master (
    output board7SD, enable, brightness, blinkEn,
    input  anN, segN, dpN, frameStart
  );

  modport slave (
    input  board7SD, enable, brightness, blinkEn,
    output anN, segN, dpN, frameStart
  );

endinterface

// File: rtl/refresh_prescaler.sv
// Free-running digit-slot prescaler; tick marks the last clock of each slot.
module refresh_prescaler #(
  parameter int DIV_LOG2 = 17
) (
  input  logic                clk,
  input  logic                rstN,
  output logic [DIV_LOG2-1:0] pre,
  output logic                tick
);

  // Wrapping up-counter over one digit slot.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pre <= '0;
    end else begin
      pre <= pre + DIV_LOG2'(1);
    end
  end

  assign tick = &pre;

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit 7-segment driver. The segment image is captured
// once per frame (tear-free), each digit slot starts with a dark blanking
// window, the lit part of the slot is trimmed by brightness, and selected
// digits can blink at a frame-derived rate.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIV_LOG2          = 17,
  parameter int BLANK_CYCLES      = 64,
  parameter int BLINK_FRAMES_LOG2 = 6
) (
  input logic                clk,
  input logic                rstN,
  seven_seg_scanner_if.slave bus
);

  localparam logic [DIV_LOG2-1:0] BLANK_THR = DIV_LOG2'(BLANK_CYCLES);

  logic [DIV_LOG2-1:0]           pre;
  logic                          tick;
  logic                          latch;
  digit_t                        dig_reg;
  logic [NUM_DIGITS*SEG_W-1:0]   shadow_reg;
  logic                          frame_start_reg;
  logic [BLINK_FRAMES_LOG2-1:0]  frame_cnt_reg;
  logic                          blink_ph_reg;
  logic [NUM_DIGITS-1:0]         dig_onehot;
  logic [SEG_W-1:0]              cur_byte;
  logic                          digit_on;
  drive_t                        drive_next;
  drive_t                        drive_reg;

  refresh_prescaler #(
    .DIV_LOG2(DIV_LOG2)
  ) u_prescaler (
    .clk  (clk),
    .rstN (rstN),
    .pre  (pre),
    .tick (tick)
  );

  // The image is captured at the end of the last digit's slot, so a whole
  // frame is always drawn from a single snapshot.
  assign latch = tick && (dig_reg == digit_t'(NUM_DIGITS - 1));

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig_decode
    assign dig_onehot[gi] = (dig_reg == digit_t'(gi));
  end

  // Digit index advance, frame snapshot and frame-start pulse.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      dig_reg         <= '0;
      shadow_reg      <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= latch;
      if (tick) begin
        dig_reg <= dig_reg + digit_t'(1);
      end
      if (latch) begin
        shadow_reg <= bus.board7SD;
      end
    end
  end

  // Blink phase flips every 2^BLINK_FRAMES_LOG2 captured frames.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      frame_cnt_reg <= '0;
      blink_ph_reg  <= 1'b0;
    end else if (latch) begin
      frame_cnt_reg <= frame_cnt_reg + BLINK_FRAMES_LOG2'(1);
      if (&frame_cnt_reg) begin
        blink_ph_reg <= ~blink_ph_reg;
      end
    end
  end

  // Decide whether the current digit is lit this cycle and what it shows.
  // Blanking at the head of every slot keeps the anode dark across every
  // digit change, including the 3->0 wrap, regardless of brightness.
  always_comb begin
    cur_byte   = digit_byte(shadow_reg, dig_reg);
    digit_on   = bus.enable
              && (pre >= BLANK_THR)
              && (pre[DIV_LOG2-1 -: 3] <= bus.brightness)
              && !(bus.blinkEn[dig_reg] && blink_ph_reg);
    drive_next = DRIVE_OFF;
    if (digit_on) begin
      drive_next.an_n  = ~dig_onehot;
      drive_next.seg_n = ~cur_byte[6:0];
      drive_next.dp_n  = ~cur_byte[7];
    end
  end

  // Pin drivers are registered so the pads never see combinational glitches.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      drive_reg <= DRIVE_OFF;
    end else begin
      drive_reg <= drive_next;
    end
  end

  assign bus.anN        = drive_reg.an_n;
  assign bus.segN       = drive_reg.seg_n;
  assign bus.dpN        = drive_reg.dp_n;
  assign bus.frameStart = frame_start_reg;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with a small slot (16 clocks)
// so several frames fit in a short run. The reference model derives every
// expected pin value from the absolute clock count since reset release.
module tb_seven_seg_scanner;

  localparam int DIV_LOG2          = 4;
  localparam int BLANK_CYCLES      = 2;
  localparam int BLINK_FRAMES_LOG2 = 1;
  localparam int SLOT              = 1 << DIV_LOG2;
  localparam int FRAME             = 4 * SLOT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  seven_seg_scanner_if bus ();

  seven_seg_scanner #(
    .DIV_LOG2          (DIV_LOG2),
    .BLANK_CYCLES      (BLANK_CYCLES),
    .BLINK_FRAMES_LOG2 (BLINK_FRAMES_LOG2)
  ) dut (
    .clk  (clk),
    .rstN (rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: clock k after release sits at slot position k%SLOT of
  // digit (k/SLOT)%4 in frame k/FRAME; the frame shows the image sampled on
  // the edge that ended the previous frame; blinking digits hide in frames
  // whose index has bit BLINK_FRAMES_LOG2 set.
  int          k;
  logic [31:0] m_image;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_fs;

  always @(posedge clk or negedge rst_n) begin : model
    int       pos;
    int       dig;
    int       frame;
    bit       lit;
    bit       last;
    logic [7:0] b;
    if (!rst_n) begin
      k       <= 0;
      m_image <= '0;
      exp_an  <= 4'hF;
      exp_seg <= 7'h7F;
      exp_dp  <= 1'b1;
      exp_fs  <= 1'b0;
    end else begin
      pos   = k % SLOT;
      dig   = (k / SLOT) % 4;
      frame = k / FRAME;
      lit   = bus.enable
           && (pos >= BLANK_CYCLES)
           && ((pos * 8) / SLOT <= int'(bus.brightness))
           && !(bus.blinkEn[dig] && (((frame >> BLINK_FRAMES_LOG2) & 1) == 1));
      b     = m_image[8*dig +: 8];
      last  = (k % FRAME) == FRAME - 1;
      exp_an  <= lit ? ~(4'b0001 << dig) : 4'hF;
      exp_seg <= lit ? ~b[6:0] : 7'h7F;
      exp_dp  <= lit ? ~b[7] : 1'b1;
      exp_fs  <= last;
      if (last) m_image <= bus.board7SD;
      k <= k + 1;
    end
  end

  task automatic test_reset();
    logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    int on_cnt [4] = '{0, 0, 0, 0};
    int first_fs = -1;
    int seg_bad  = 0;
    rst_n = 1'b0;
    bus.enable = 1'b1; bus.brightness = 3'd7; bus.blinkEn = 4'h0;
    bus.board7SD = $urandom;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.anN, bus.segN, bus.dpN, bus.frameStart} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_hold: got an=%h seg=%h dp=%b fs=%b, want F/7F/1/0",
               bus.anN, bus.segN, bus.dpN, bus.frameStart);
    end
    rst_n = 1'b1;
    for (int j = 1; j <= 80; j++) begin
      @(negedge clk);
      checks++;
      if ({bus.anN, bus.segN, bus.dpN, bus.frameStart} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
        failures++;
        $display("FAIL reset_model j=%0d: got %h/%h/%b/%b want %h/%h/%b/%b", j,
                 bus.anN, bus.segN, bus.dpN, bus.frameStart, exp_an, exp_seg, exp_dp, exp_fs);
      end
      if (bus.frameStart && first_fs < 0) first_fs = j;
      if (j <= 64) begin
        if (bus.anN == an_tab[(j-1)/16]) on_cnt[(j-1)/16]++;
        if (bus.segN !== 7'h7F) seg_bad++;
      end
    end
    checks++;
    if (first_fs != 64) begin
      failures++;
      $display("FAIL reset_first_frame: got %0d clocks, want 64", first_fs);
    end
    checks++;
    if (seg_bad != 0) begin
      failures++;
      $display("FAIL reset_blank_image: got %0d lit-segment cycles, want 0", seg_bad);
    end
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (on_cnt[s] != 14) begin
        failures++;
        $display("FAIL reset_anode_slot%0d: got %0d cycles of an=%h, want 14", s, on_cnt[s], an_tab[s]);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_image_decode();
    int cnt_e = 0, cnt_d = 0, cnt_7 = 0;
    bit seen = 1'b0;
    bus.board7SD = 32'h3F06DB4F; bus.brightness = 3'd7; bus.blinkEn = 4'h0; bus.enable = 1'b1;
    for (int j = 0; j < 200 && !seen; j++) begin
      @(negedge clk);
      seen = bus.frameStart;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL decode_wait_frame: got no frameStart in 200 clocks, want one");
      return;
    end
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      checks++;
      if ({bus.anN, bus.segN, bus.dpN, bus.frameStart} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
        failures++;
        $display("FAIL decode_model: got %h/%h/%b/%b want %h/%h/%b/%b",
                 bus.anN, bus.segN, bus.dpN, bus.frameStart, exp_an, exp_seg, exp_dp, exp_fs);
      end
      if (bus.anN == 4'hE && bus.segN == 7'h30 && bus.dpN == 1'b1) cnt_e++;
      if (bus.anN == 4'hD && bus.segN == 7'h24 && bus.dpN == 1'b0) cnt_d++;
      if (bus.anN == 4'h7 && bus.segN == 7'h40 && bus.dpN == 1'b1) cnt_7++;
    end
    checks++;
    if (cnt_e != 14) begin failures++; $display("FAIL decode_digit0: got %0d cycles, want 14", cnt_e); end
    checks++;
    if (cnt_d != 14) begin failures++; $display("FAIL decode_digit1: got %0d cycles, want 14", cnt_d); end
    checks++;
    if (cnt_7 != 14) begin failures++; $display("FAIL decode_digit3: got %0d cycles, want 14", cnt_7); end
    $display("test_image_decode done");
  endtask

  task automatic test_tear_free();
    bit seen = 1'b0;
    int old_bad = 0, old_cnt = 0, new_bad = 0, new_on = 0;
    for (int j = 0; j < 80 && !seen; j++) begin
      @(negedge clk);
      seen = (bus.anN == 4'hD);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL tear_wait_digit1: got no an=D in 80 clocks, want one");
      return;
    end
    bus.board7SD = 32'h0;
    seen = 1'b0;
    for (int j = 0; j < 80 && !seen; j++) begin
      @(negedge clk);
      seen = bus.frameStart;
      if (bus.anN == 4'hD && bus.segN != 7'h24) old_bad++;
      if (bus.anN == 4'hB && bus.segN != 7'h79) old_bad++;
      if (bus.anN == 4'h7 && bus.segN != 7'h40) old_bad++;
      if (bus.anN == 4'hB || bus.anN == 4'h7) old_cnt++;
    end
    checks++;
    if (!seen || old_bad != 0 || old_cnt != 28) begin
      failures++;
      $display("FAIL tear_old_frame: got latch=%b wrong=%0d lit=%0d, want latch=1 wrong=0 lit=28",
               seen, old_bad, old_cnt);
    end
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      checks++;
      if ({bus.anN, bus.segN, bus.dpN, bus.frameStart} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
        failures++;
        $display("FAIL tear_model: got %h/%h/%b/%b want %h/%h/%b/%b",
                 bus.anN, bus.segN, bus.dpN, bus.frameStart, exp_an, exp_seg, exp_dp, exp_fs);
      end
      if (bus.segN != 7'h7F) new_bad++;
      if (bus.anN != 4'hF) new_on++;
    end
    checks++;
    if (new_bad != 0 || new_on != 56) begin
      failures++;
      $display("FAIL tear_new_frame: got lit-seg=%0d on=%0d, want 0 and 56", new_bad, new_on);
    end
    $display("test_tear_free done");
  endtask

  task automatic test_brightness();
    int on_cnt;
    logic [2:0] lvl [2] = '{3'd1, 3'd0};
    int want [2] = '{8, 0};
    bus.board7SD = 32'hFFFFFFFF;
    for (int t = 0; t < 2; t++) begin
      bus.brightness = lvl[t];
      on_cnt = 0;
      for (int j = 0; j < FRAME; j++) begin
        @(negedge clk);
        if (bus.anN != 4'hF) on_cnt++;
      end
      checks++;
      if (on_cnt != want[t]) begin
        failures++;
        $display("FAIL brightness_%0d: got %0d lit cycles per frame, want %0d", lvl[t], on_cnt, want[t]);
      end
    end
    bus.brightness = 3'd7;
    $display("test_brightness done");
  endtask

  task automatic test_blink();
    int b_cnt, other_cnt, want_b;
    rst_n = 1'b0;
    bus.blinkEn = 4'b0100; bus.brightness = 3'd7; bus.enable = 1'b1;
    bus.board7SD = $urandom | 32'h01010101;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int f = 0; f < 8; f++) begin
      b_cnt = 0; other_cnt = 0;
      for (int j = 0; j < FRAME; j++) begin
        @(negedge clk);
        checks++;
        if ({bus.anN, bus.segN, bus.dpN, bus.frameStart} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
          failures++;
          $display("FAIL blink_model f=%0d: got %h/%h/%b/%b want %h/%h/%b/%b", f,
                   bus.anN, bus.segN, bus.dpN, bus.frameStart, exp_an, exp_seg, exp_dp, exp_fs);
        end
        if (bus.anN == 4'hB) b_cnt++;
        else if (bus.anN != 4'hF) other_cnt++;
      end
      want_b = ((f >> 1) & 1) ? 0 : 14;
      checks++;
      if (b_cnt != want_b) begin
        failures++;
        $display("FAIL blink_digit2 f=%0d: got %0d lit cycles, want %0d", f, b_cnt, want_b);
      end
      checks++;
      if (other_cnt != 42) begin
        failures++;
        $display("FAIL blink_others f=%0d: got %0d lit cycles, want 42", f, other_cnt);
      end
    end
    bus.blinkEn = 4'h0;
    $display("test_blink done");
  endtask

  task automatic test_random();
    for (int j = 0; j < 6 * FRAME; j++) begin
      @(negedge clk);
      checks++;
      if ({bus.anN, bus.segN, bus.dpN, bus.frameStart} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
        failures++;
        $display("FAIL random_model j=%0d: got %h/%h/%b/%b want %h/%h/%b/%b", j,
                 bus.anN, bus.segN, bus.dpN, bus.frameStart, exp_an, exp_seg, exp_dp, exp_fs);
      end
      if ($urandom_range(0, 15) == 0) bus.board7SD = $urandom;
      if ($urandom_range(0, 7) == 0) bus.brightness = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) bus.blinkEn = 4'($urandom_range(0, 15));
      bus.enable = ($urandom_range(0, 9) != 0);
    end
    bus.enable = 1'b1; bus.brightness = 3'd7; bus.blinkEn = 4'h0;
    $display("test_random done");
  endtask

  task automatic test_mid_slot_reset();
    int first_fs = -1;
    int seg_bad  = 0;
    rst_n = 1'b0;
    bus.board7SD = 32'h3F06DB4F; bus.enable = 1'b1; bus.brightness = 3'd7; bus.blinkEn = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME + 2 * SLOT + 7) @(negedge clk);
    checks++;
    if (bus.anN !== 4'hB || bus.segN !== 7'h79) begin
      failures++;
      $display("FAIL midreset_before: got an=%h seg=%h, want B/79", bus.anN, bus.segN);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.anN, bus.segN, bus.dpN, bus.frameStart} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL midreset_async: got %h/%h/%b/%b, want F/7F/1/0",
               bus.anN, bus.segN, bus.dpN, bus.frameStart);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 1; j <= 70; j++) begin
      @(negedge clk);
      checks++;
      if ({bus.anN, bus.segN, bus.dpN, bus.frameStart} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
        failures++;
        $display("FAIL midreset_model j=%0d: got %h/%h/%b/%b want %h/%h/%b/%b", j,
                 bus.anN, bus.segN, bus.dpN, bus.frameStart, exp_an, exp_seg, exp_dp, exp_fs);
      end
      if (bus.frameStart && first_fs < 0) first_fs = j;
      if (j <= 64 && bus.segN !== 7'h7F) seg_bad++;
      if (j == 3) begin
        checks++;
        if (bus.anN !== 4'hE) begin
          failures++;
          $display("FAIL midreset_restart_digit: got an=%h, want E", bus.anN);
        end
      end
    end
    checks++;
    if (first_fs != 64 || seg_bad != 0) begin
      failures++;
      $display("FAIL midreset_first_frame: got fs at %0d lit-seg=%0d, want 64 and 0", first_fs, seg_bad);
    end
    $display("test_mid_slot_reset done");
  endtask

  initial begin
    bus.board7SD = '0; bus.enable = 1'b0; bus.brightness = 3'd0; bus.blinkEn = 4'h0;
    test_reset();
    test_image_decode();
    test_tear_free();
    test_brightness();
    test_blink();
    test_random();
    test_mid_slot_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
